bridge_nxm: RTL and testbench

//  Shared-bus AXI-Lite interconnect: N masters to M address-decoded slaves; next generation of bridge_1xM.

---
 rtl/bridge_pkg.sv | 45 ++++
 rtl/axi_lite_if.sv | 38 +++
 rtl/bridge_nxm_arb.sv | 49 ++++
 rtl/bridge_nxm.sv | 330 +++++++++++++++++++++++++++++++++
 tb/tb_bridge_nxm.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bridge_pkg.sv
// Shared types and helpers for the N x M AXI-Lite bridge.
// Response codes, FSM state enums and the address decoder.
package bridge_pkg;

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_SLVERR = 2'b10;
  localparam logic [1:0] AXI_DECERR = 2'b11;

  localparam int MAXM = 16;

  typedef enum logic [2:0] {
    W_IDLE, W_FWD, W_DEC, W_RESP, W_DRESP
  } w_state_t;

  typedef enum logic [2:0] {
    R_IDLE, R_FWD, R_DEC, R_RESP, R_DRESP
  } r_state_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } dec_t;

  // Lowest matching region wins when regions overlap.
  function automatic dec_t decode(
    input logic [63:0]        addr,
    input logic [MAXM*64-1:0] base,
    input logic [MAXM*64-1:0] size,
    input int                 m
  );
    dec_t r;
    r.hit = 1'b0;
    r.idx = 4'd0;
    for (int i = MAXM - 1; i >= 0; i--) begin
      if (i < m &&
          addr >= base[i*64 +: 64] &&
          (addr - base[i*64 +: 64]) < size[i*64 +: 64]) begin
        r.hit = 1'b1;
        r.idx = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI-Lite channel bundle.
// slv: seen by a slave; mst: seen by a master.
interface axi_lite_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          aw_valid;
  logic          aw_ready;
  logic [AW-1:0] aw_addr;
  logic          w_valid;
  logic          w_ready;
  logic [DW-1:0] w_data;
  logic [DW/8-1:0] w_strb;
  logic          b_valid;
  logic          b_ready;
  logic [1:0]    b_resp;
  logic          ar_valid;
  logic          ar_ready;
  logic [AW-1:0] ar_addr;
  logic          r_valid;
  logic          r_ready;
  logic [DW-1:0] r_data;
  logic [1:0]    r_resp;

  modport slv (
    input  aw_valid, aw_addr, w_valid, w_data, w_strb,
    input  b_ready, ar_valid, ar_addr, r_ready,
    output aw_ready, w_ready, b_valid, b_resp,
    output ar_ready, r_valid, r_data, r_resp
  );

  modport mst (
    output aw_valid, aw_addr, w_valid, w_data, w_strb,
    output b_ready, ar_valid, ar_addr, r_ready,
    input  aw_ready, w_ready, b_valid, b_resp,
    input  ar_ready, r_valid, r_data, r_resp
  );
endinterface

// File: rtl/bridge_nxm_arb.sv
// Round-robin arbiter: first requester at/after ptr wins.
// ptr moves to just past the served master on advance_i.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req_i,
  input  logic          advance_i,
  input  logic [IW-1:0] adv_idx_i,
  output logic [IW-1:0] grant_idx_o,
  output logic          grant_vld_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  int            c;

  // Next pointer: one past the master just served, wrapping at N.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      if (int'(adv_idx_i) >= N - 1) ptr_d = '0;
      else ptr_d = adv_idx_i + 1'b1;
    end
  end

  // Cyclic search; walking down lets the nearest requester win.
  always_comb begin
    grant_idx_o = '0;
    grant_vld_o = 1'b0;
    c = 0;
    for (int i = N - 1; i >= 0; i--) begin
      c = int'(ptr_q) + i;
      if (c >= N) c = c - N;
      if (req_i[c]) begin
        grant_idx_o = IW'(c);
        grant_vld_o = 1'b1;
      end
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/bridge_nxm.sv
// N-master, M-slave AXI-Lite shared-bus interconnect.
// Independent write/read paths, one transaction each.
module bridge_nxm
  import bridge_pkg::*;
#(
  parameter int N          = 2,
  parameter int M          = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [M*ADDR_WIDTH-1:0] BASE_ADDR_PACKED =
    {32'h3000, 32'h2000, 32'h1000, 32'h0000},
  parameter logic [M*ADDR_WIDTH-1:0] SIZE_PACKED =
    {4{32'h1000}}
) (
  input logic     clk,
  input logic     rst_n,
  axi_lite_if.slv m_axi [N],
  axi_lite_if.mst s_axi [M]
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int SB = DW / 8;

  function automatic logic [MAXM*64-1:0] widen(
    input logic [M*AW-1:0] p
  );
    logic [MAXM*64-1:0] r;
    r = '0;
    for (int i = 0; i < M; i++)
      r[i*64 +: 64] = 64'(p[i*AW +: AW]);
    return r;
  endfunction

  localparam logic [MAXM*64-1:0] BASE_W =
    widen(BASE_ADDR_PACKED);
  localparam logic [MAXM*64-1:0] SIZE_W =
    widen(SIZE_PACKED);

  logic          m_awv [N];
  logic [AW-1:0] m_awa [N];
  logic          m_wv  [N];
  logic [DW-1:0] m_wd  [N];
  logic [SB-1:0] m_ws  [N];
  logic          m_br  [N];
  logic          m_arv [N];
  logic [AW-1:0] m_ara [N];
  logic          m_rr  [N];
  logic          m_awr [N];
  logic          m_wr  [N];
  logic          m_bv  [N];
  logic [1:0]    m_bre [N];
  logic          m_arr [N];
  logic          m_rv  [N];
  logic [DW-1:0] m_rd  [N];
  logic [1:0]    m_rre [N];

  logic          s_awr [M];
  logic          s_wr  [M];
  logic          s_bv  [M];
  logic [1:0]    s_bre [M];
  logic          s_arr [M];
  logic          s_rv  [M];
  logic [DW-1:0] s_rd  [M];
  logic [1:0]    s_rre [M];
  logic          s_awv [M];
  logic          s_wv  [M];
  logic          s_br  [M];
  logic          s_arv [M];
  logic          s_rr  [M];

  logic [N-1:0]  aw_req, ar_req;

  for (genvar k = 0; k < N; k++) begin : g_m
    assign m_awv[k]  = m_axi[k].aw_valid;
    assign m_awa[k]  = m_axi[k].aw_addr;
    assign m_wv[k]   = m_axi[k].w_valid;
    assign m_wd[k]   = m_axi[k].w_data;
    assign m_ws[k]   = m_axi[k].w_strb;
    assign m_br[k]   = m_axi[k].b_ready;
    assign m_arv[k]  = m_axi[k].ar_valid;
    assign m_ara[k]  = m_axi[k].ar_addr;
    assign m_rr[k]   = m_axi[k].r_ready;
    assign aw_req[k] = m_axi[k].aw_valid;
    assign ar_req[k] = m_axi[k].ar_valid;
    assign m_axi[k].aw_ready = m_awr[k];
    assign m_axi[k].w_ready  = m_wr[k];
    assign m_axi[k].b_valid  = m_bv[k];
    assign m_axi[k].b_resp   = m_bre[k];
    assign m_axi[k].ar_ready = m_arr[k];
    assign m_axi[k].r_valid  = m_rv[k];
    assign m_axi[k].r_data   = m_rd[k];
    assign m_axi[k].r_resp   = m_rre[k];
  end

  w_state_t      w_q, w_d;
  r_state_t      r_q, r_d;
  logic [IW-1:0] gw_q, gw_d, gr_q, gr_d;
  logic [3:0]    wt_q, wt_d, rt_q, rt_d;
  logic          awd_q, awd_d, wd_q, wd_d;
  logic          ard_q, ard_d;

  // Address and data fan out to every slave; valids are gated.
  for (genvar j = 0; j < M; j++) begin : g_s
    assign s_awr[j] = s_axi[j].aw_ready;
    assign s_wr[j]  = s_axi[j].w_ready;
    assign s_bv[j]  = s_axi[j].b_valid;
    assign s_bre[j] = s_axi[j].b_resp;
    assign s_arr[j] = s_axi[j].ar_ready;
    assign s_rv[j]  = s_axi[j].r_valid;
    assign s_rd[j]  = s_axi[j].r_data;
    assign s_rre[j] = s_axi[j].r_resp;
    assign s_axi[j].aw_valid = s_awv[j];
    assign s_axi[j].aw_addr  = m_awa[gw_q];
    assign s_axi[j].w_valid  = s_wv[j];
    assign s_axi[j].w_data   = m_wd[gw_q];
    assign s_axi[j].w_strb   = m_ws[gw_q];
    assign s_axi[j].b_ready  = s_br[j];
    assign s_axi[j].ar_valid = s_arv[j];
    assign s_axi[j].ar_addr  = m_ara[gr_q];
    assign s_axi[j].r_ready  = s_rr[j];
  end

  logic [IW-1:0] aw_gidx, ar_gidx;
  logic          aw_gvld, ar_gvld;
  logic          w_adv, r_adv;

  rr_arbiter #(.N(N)) u_aw_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (aw_req),
    .advance_i  (w_adv),
    .adv_idx_i  (gw_q),
    .grant_idx_o(aw_gidx),
    .grant_vld_o(aw_gvld)
  );

  rr_arbiter #(.N(N)) u_ar_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (ar_req),
    .advance_i  (r_adv),
    .adv_idx_i  (gr_q),
    .grant_idx_o(ar_gidx),
    .grant_vld_o(ar_gvld)
  );

  dec_t wdec, rdec;
  logic aw_hs, w_hs, ar_hs;

  // Write path: grant, decode, route AW/W, then route or fake B.
  always_comb begin
    w_d   = w_q;
    gw_d  = gw_q;
    wt_d  = wt_q;
    awd_d = awd_q;
    wd_d  = wd_q;
    w_adv = 1'b0;
    aw_hs = 1'b0;
    w_hs  = 1'b0;
    wdec  = '0;
    for (int k = 0; k < N; k++) begin
      m_awr[k] = 1'b0;
      m_wr[k]  = 1'b0;
      m_bv[k]  = 1'b0;
      m_bre[k] = AXI_OKAY;
    end
    for (int j = 0; j < M; j++) begin
      s_awv[j] = 1'b0;
      s_wv[j]  = 1'b0;
      s_br[j]  = 1'b0;
    end
    unique case (w_q)
      W_IDLE: begin
        wdec = decode(64'(m_awa[aw_gidx]),
                      BASE_W, SIZE_W, M);
        if (aw_gvld) begin
          gw_d  = aw_gidx;
          wt_d  = wdec.idx;
          awd_d = 1'b0;
          wd_d  = 1'b0;
          w_d   = wdec.hit ? W_FWD : W_DEC;
        end
      end
      W_FWD: begin
        s_awv[wt_q] = m_awv[gw_q] & ~awd_q;
        m_awr[gw_q] = s_awr[wt_q] & ~awd_q;
        s_wv[wt_q]  = m_wv[gw_q] & ~wd_q;
        m_wr[gw_q]  = s_wr[wt_q] & ~wd_q;
        aw_hs = m_awv[gw_q] & s_awr[wt_q] & ~awd_q;
        w_hs  = m_wv[gw_q] & s_wr[wt_q] & ~wd_q;
        if (aw_hs) awd_d = 1'b1;
        if (w_hs)  wd_d  = 1'b1;
        if ((awd_q | aw_hs) && (wd_q | w_hs))
          w_d = W_RESP;
      end
      W_DEC: begin
        m_awr[gw_q] = ~awd_q;
        m_wr[gw_q]  = ~wd_q;
        aw_hs = m_awv[gw_q] & ~awd_q;
        w_hs  = m_wv[gw_q] & ~wd_q;
        if (aw_hs) awd_d = 1'b1;
        if (w_hs)  wd_d  = 1'b1;
        if ((awd_q | aw_hs) && (wd_q | w_hs))
          w_d = W_DRESP;
      end
      W_RESP: begin
        m_bv[gw_q]  = s_bv[wt_q];
        m_bre[gw_q] = s_bre[wt_q];
        s_br[wt_q]  = m_br[gw_q];
        if (s_bv[wt_q] && m_br[gw_q]) begin
          w_adv = 1'b1;
          w_d   = W_IDLE;
        end
      end
      W_DRESP: begin
        m_bv[gw_q]  = 1'b1;
        m_bre[gw_q] = AXI_DECERR;
        if (m_br[gw_q]) begin
          w_adv = 1'b1;
          w_d   = W_IDLE;
        end
      end
      default: w_d = W_IDLE;
    endcase
  end

  // Read path: same shape as the write path on AR/R.
  always_comb begin
    r_d   = r_q;
    gr_d  = gr_q;
    rt_d  = rt_q;
    ard_d = ard_q;
    r_adv = 1'b0;
    ar_hs = 1'b0;
    rdec  = '0;
    for (int k = 0; k < N; k++) begin
      m_arr[k] = 1'b0;
      m_rv[k]  = 1'b0;
      m_rd[k]  = '0;
      m_rre[k] = AXI_OKAY;
    end
    for (int j = 0; j < M; j++) begin
      s_arv[j] = 1'b0;
      s_rr[j]  = 1'b0;
    end
    unique case (r_q)
      R_IDLE: begin
        rdec = decode(64'(m_ara[ar_gidx]),
                      BASE_W, SIZE_W, M);
        if (ar_gvld) begin
          gr_d  = ar_gidx;
          rt_d  = rdec.idx;
          ard_d = 1'b0;
          r_d   = rdec.hit ? R_FWD : R_DEC;
        end
      end
      R_FWD: begin
        s_arv[rt_q] = m_arv[gr_q] & ~ard_q;
        m_arr[gr_q] = s_arr[rt_q] & ~ard_q;
        ar_hs = m_arv[gr_q] & s_arr[rt_q] & ~ard_q;
        if (ar_hs) begin
          ard_d = 1'b1;
          r_d   = R_RESP;
        end
      end
      R_DEC: begin
        m_arr[gr_q] = ~ard_q;
        ar_hs = m_arv[gr_q] & ~ard_q;
        if (ar_hs) begin
          ard_d = 1'b1;
          r_d   = R_DRESP;
        end
      end
      R_RESP: begin
        m_rv[gr_q]  = s_rv[rt_q];
        m_rd[gr_q]  = s_rd[rt_q];
        m_rre[gr_q] = s_rre[rt_q];
        s_rr[rt_q]  = m_rr[gr_q];
        if (s_rv[rt_q] && m_rr[gr_q]) begin
          r_adv = 1'b1;
          r_d   = R_IDLE;
        end
      end
      R_DRESP: begin
        m_rv[gr_q]  = 1'b1;
        m_rre[gr_q] = AXI_DECERR;
        if (m_rr[gr_q]) begin
          r_adv = 1'b1;
          r_d   = R_IDLE;
        end
      end
      default: r_d = R_IDLE;
    endcase
  end

  // Write path state, grant, target and done flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q   <= W_IDLE;
      gw_q  <= '0;
      wt_q  <= '0;
      awd_q <= 1'b0;
      wd_q  <= 1'b0;
    end else begin
      w_q   <= w_d;
      gw_q  <= gw_d;
      wt_q  <= wt_d;
      awd_q <= awd_d;
      wd_q  <= wd_d;
    end
  end

  // Read path state, grant, target and done flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= R_IDLE;
      gr_q  <= '0;
      rt_q  <= '0;
      ard_q <= 1'b0;
    end else begin
      r_q   <= r_d;
      gr_q  <= gr_d;
      rt_q  <= rt_d;
      ard_q <= ard_d;
    end
  end

endmodule

// File: tb/tb_bridge_nxm.sv
// Directed bench for bridge_nxm: 2 masters, 4 memory slaves.
// Vector table plus hand-written arbitration/reset sequences.
module tb_bridge_nxm;

  localparam int N = 2;
  localparam int M = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_lite_if #(.AW(32), .DW(32)) m_if [N] ();
  axi_lite_if #(.AW(32), .DW(32)) s_if [M] ();

  bridge_nxm #(.N(N), .M(M)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .m_axi(m_if),
    .s_axi(s_if)
  );

  logic        mawv [N];
  logic [31:0] mawa [N];
  logic        mwv  [N];
  logic [31:0] mwd  [N];
  logic        mbr  [N];
  logic        marv [N];
  logic [31:0] mara [N];
  logic        mrr  [N];
  logic        mawr [N];
  logic        mwr  [N];
  logic        mbv  [N];
  logic [1:0]  mbre [N];
  logic        marr [N];
  logic        mrv  [N];
  logic [31:0] mrd  [N];
  logic [1:0]  mrre [N];

  for (genvar k = 0; k < N; k++) begin : g_m
    assign m_if[k].aw_valid = mawv[k];
    assign m_if[k].aw_addr  = mawa[k];
    assign m_if[k].w_valid  = mwv[k];
    assign m_if[k].w_data   = mwd[k];
    assign m_if[k].w_strb   = 4'hF;
    assign m_if[k].b_ready  = mbr[k];
    assign m_if[k].ar_valid = marv[k];
    assign m_if[k].ar_addr  = mara[k];
    assign m_if[k].r_ready  = mrr[k];
    assign mawr[k] = m_if[k].aw_ready;
    assign mwr[k]  = m_if[k].w_ready;
    assign mbv[k]  = m_if[k].b_valid;
    assign mbre[k] = m_if[k].b_resp;
    assign marr[k] = m_if[k].ar_ready;
    assign mrv[k]  = m_if[k].r_valid;
    assign mrd[k]  = m_if[k].r_data;
    assign mrre[k] = m_if[k].r_resp;
  end

  logic         sawv [M];
  logic         swv  [M];
  logic         sbr  [M];
  logic         srr  [M];
  logic [M-1:0] sarv;

  // Simple memory slave: accepts AW/W, then B; AR, then R.
  for (genvar j = 0; j < M; j++) begin : g_s
    logic [31:0] mem [1024];
    logic        awg, wg, bv, rv;
    logic [9:0]  aa;
    logic [31:0] wdat, rdat;
    assign sawv[j] = s_if[j].aw_valid;
    assign swv[j]  = s_if[j].w_valid;
    assign sbr[j]  = s_if[j].b_ready;
    assign sarv[j] = s_if[j].ar_valid;
    assign srr[j]  = s_if[j].r_ready;
    assign s_if[j].aw_ready = !awg && !bv;
    assign s_if[j].w_ready  = !wg && !bv;
    assign s_if[j].b_valid  = bv;
    assign s_if[j].b_resp   = 2'b00;
    assign s_if[j].ar_ready = !rv;
    assign s_if[j].r_valid  = rv;
    assign s_if[j].r_data   = rdat;
    assign s_if[j].r_resp   = 2'b00;
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        awg  <= 1'b0;
        wg   <= 1'b0;
        bv   <= 1'b0;
        rv   <= 1'b0;
        aa   <= '0;
        wdat <= '0;
        rdat <= '0;
      end else begin
        if (s_if[j].aw_valid && !awg && !bv) begin
          awg <= 1'b1;
          aa  <= s_if[j].aw_addr[11:2];
        end
        if (s_if[j].w_valid && !wg && !bv) begin
          wg   <= 1'b1;
          wdat <= s_if[j].w_data;
        end
        if (awg && wg && !bv) begin
          mem[aa] <= wdat;
          bv  <= 1'b1;
          awg <= 1'b0;
          wg  <= 1'b0;
        end
        if (bv && s_if[j].b_ready) bv <= 1'b0;
        if (s_if[j].ar_valid && !rv) begin
          rv   <= 1'b1;
          rdat <= mem[s_if[j].ar_addr[11:2]];
        end else if (rv && s_if[j].r_ready) begin
          rv <= 1'b0;
        end
      end
    end
  end

  int ar_seen = 0;
  always @(posedge clk)
    if (|sarv) ar_seen <= ar_seen + 1;

  int aw_log [$];
  always @(posedge clk)
    for (int k = 0; k < N; k++)
      if (mawv[k] && mawr[k]) aw_log.push_back(k);

  logic outs_any;
  always_comb begin
    outs_any = 1'b0;
    for (int k = 0; k < N; k++)
      outs_any = outs_any | mawr[k] | mwr[k] | mbv[k] |
                 marr[k] | mrv[k] | (|mbre[k]) |
                 (|mrre[k]) | (|mrd[k]);
    for (int j = 0; j < M; j++)
      outs_any = outs_any | sawv[j] | swv[j] | sbr[j] |
                 sarv[j] | srr[j];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input int k, input logic [31:0] a,
                    input logic [31:0] d,
                    output logic [1:0] resp);
    int   t;
    logic awh, wh, ad, wdn, got;
    resp = 2'b01;
    @(negedge clk);
    mawv[k] = 1'b1; mawa[k] = a;
    mwv[k]  = 1'b1; mwd[k]  = d;
    mbr[k]  = 1'b1;
    ad = 1'b0; wdn = 1'b0; got = 1'b0; t = 0;
    while (!(ad && wdn) && t < 200) begin
      #1;
      awh = mawv[k] & mawr[k];
      wh  = mwv[k] & mwr[k];
      @(negedge clk); t++;
      if (awh) begin mawv[k] = 1'b0; ad = 1'b1; end
      if (wh)  begin mwv[k]  = 1'b0; wdn = 1'b1; end
    end
    while (!got && t < 200) begin
      #1;
      if (mbv[k]) begin resp = mbre[k]; got = 1'b1; end
      @(negedge clk); t++;
    end
    mbr[k] = 1'b0; mawv[k] = 1'b0; mwv[k] = 1'b0;
    chk("wr_done", {31'b0, got}, 32'd1);
  endtask

  task automatic rd(input int k, input logic [31:0] a,
                    output logic [1:0] resp,
                    output logic [31:0] data);
    int   t;
    logic arh, dn, got;
    resp = 2'b01; data = '0;
    @(negedge clk);
    marv[k] = 1'b1; mara[k] = a; mrr[k] = 1'b1;
    dn = 1'b0; got = 1'b0; t = 0;
    while (!dn && t < 200) begin
      #1;
      arh = marr[k];
      @(negedge clk); t++;
      if (arh) begin marv[k] = 1'b0; dn = 1'b1; end
    end
    while (!got && t < 200) begin
      #1;
      if (mrv[k]) begin
        resp = mrre[k]; data = mrd[k]; got = 1'b1;
      end
      @(negedge clk); t++;
    end
    mrr[k] = 1'b0; marv[k] = 1'b0;
    chk("rd_done", {31'b0, got}, 32'd1);
  endtask

  typedef struct {
    int          k;
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  eresp;
    logic [31:0] edata;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  r0, r1;
    logic [31:0] d1;
    int          ars;
    tbl[0]  = '{0, 1'b1, 32'h0000,  32'hDEAD_0000, 2'b00, 32'h0};
    tbl[1]  = '{0, 1'b1, 32'h1000,  32'hDEAD_1000, 2'b00, 32'h0};
    tbl[2]  = '{0, 1'b1, 32'h2000,  32'hDEAD_2000, 2'b00, 32'h0};
    tbl[3]  = '{0, 1'b1, 32'h3000,  32'hDEAD_3000, 2'b00, 32'h0};
    tbl[4]  = '{1, 1'b0, 32'h0000,  32'h0, 2'b00, 32'hDEAD_0000};
    tbl[5]  = '{1, 1'b0, 32'h1000,  32'h0, 2'b00, 32'hDEAD_1000};
    tbl[6]  = '{1, 1'b0, 32'h2000,  32'h0, 2'b00, 32'hDEAD_2000};
    tbl[7]  = '{1, 1'b0, 32'h3000,  32'h0, 2'b00, 32'hDEAD_3000};
    tbl[8]  = '{1, 1'b0, 32'h1_0000, 32'h0, 2'b11, 32'h0};
    tbl[9]  = '{0, 1'b1, 32'h2_0000, 32'h1, 2'b11, 32'h0};
    tbl[10] = '{1, 1'b1, 32'h0100,  32'hBEEF_0100, 2'b00, 32'h0};
    tbl[11] = '{0, 1'b0, 32'h0100,  32'h0, 2'b00, 32'hBEEF_0100};

    for (int k = 0; k < N; k++) begin
      mawv[k] = 1'b0; mawa[k] = '0; mwv[k] = 1'b0;
      mwd[k]  = '0;   mbr[k]  = 1'b0; marv[k] = 1'b0;
      mara[k] = '0;   mrr[k]  = 1'b0;
    end

    repeat (3) @(negedge clk);
    #1;
    chk("reset_outs", {31'b0, outs_any}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].is_wr) begin
        wr(tbl[i].k, tbl[i].addr, tbl[i].data, r0);
        chk($sformatf("vec%0d_bresp", i), 32'(r0),
            32'(tbl[i].eresp));
      end else begin
        ars = ar_seen;
        rd(tbl[i].k, tbl[i].addr, r0, d1);
        chk($sformatf("vec%0d_rresp", i), 32'(r0),
            32'(tbl[i].eresp));
        chk($sformatf("vec%0d_rdata", i), d1, tbl[i].edata);
        if (tbl[i].eresp == 2'b11)
          chk($sformatf("vec%0d_no_ar", i), ar_seen, ars);
      end
    end

    aw_log.delete();
    fork
      wr(0, 32'h1004, 32'hA0A0_1004, r0);
      wr(1, 32'h2008, 32'hB1B1_2008, r1);
    join
    chk("same_cycle_resp0", 32'(r0), 32'd0);
    chk("same_cycle_resp1", 32'(r1), 32'd0);
    chk("same_cycle_n", aw_log.size(), 2);
    if (aw_log.size() == 2) begin
      chk("same_cycle_first", aw_log[0], 0);
      chk("same_cycle_second", aw_log[1], 1);
    end

    aw_log.delete();
    fork
      begin
        logic [1:0] ra;
        wr(0, 32'h0010, 32'h1111_0010, ra);
        wr(0, 32'h0014, 32'h1111_0014, ra);
      end
      begin
        logic [1:0] rb;
        wr(1, 32'h1010, 32'h2222_1010, rb);
        wr(1, 32'h1014, 32'h2222_1014, rb);
      end
    join
    chk("b2b_n", aw_log.size(), 4);
    if (aw_log.size() == 4)
      for (int i = 0; i < 4; i++)
        chk($sformatf("b2b_grant%0d", i), aw_log[i], i % 2);
    rd(1, 32'h1014, r0, d1);
    chk("b2b_readback", d1, 32'h2222_1014);

    wr(0, 32'h3010, 32'h1234_5678, r0);
    fork
      wr(0, 32'h3010, 32'hCAFE_F00D, r0);
      rd(1, 32'h3010, r1, d1);
    join
    chk("rw_same_bresp", 32'(r0), 32'd0);
    chk("rw_same_rresp", 32'(r1), 32'd0);
    chk("rw_same_data",
        {31'b0, (d1 == 32'h1234_5678) ||
                (d1 == 32'hCAFE_F00D)}, 32'd1);
    rd(0, 32'h3010, r1, d1);
    chk("rw_same_after", d1, 32'hCAFE_F00D);

    @(negedge clk);
    mawv[0] = 1'b1; mawa[0] = 32'h2000;
    mwv[0]  = 1'b1; mwd[0]  = 32'h1111_2222;
    mbr[0]  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("fwd_aw_valid", {31'b0, sawv[2]}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset_outs", {31'b0, outs_any}, 32'd0);
    mawv[0] = 1'b0; mwv[0] = 1'b0; mbr[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    wr(0, 32'h2000, 32'h5A5A_A5A5, r0);
    chk("post_rst_bresp", 32'(r0), 32'd0);
    rd(1, 32'h2000, r1, d1);
    chk("post_rst_rresp", 32'(r1), 32'd0);
    chk("post_rst_rdata", d1, 32'h5A5A_A5A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
